// File: rtl/ne_dot_pkg.sv
// ne_dot_pkg: shared defaults and FSM state type for the dot-product accumulator
package ne_dot_pkg;
    localparam int IN_W  = 31;
    localparam int ACC_W = 40;
    localparam int CNT_W = 8;

    typedef enum logic {IDLE_ACC, HOLD} acc_state_t;
endpackage

// File: rtl/ne_cpa.sv
// ne_cpa: registered carry-propagate adder resolving a redundant (sum, carry) pair, with valid/last sideband
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_sum/in_carry/in_last upstream;
//        advance (downstream consumes this cycle), valid/val/last registered stage outputs.
module ne_cpa
    import ne_dot_pkg::*;
#(
    parameter int W = IN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_sum,
    input  logic [W-1:0] in_carry,
    input  logic         in_last,
    input  logic         advance,
    output logic         valid,
    output logic [W-1:0] val,
    output logic         last
);
    assign in_ready = !valid || advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            val   <= '0;
            last  <= 1'b0;
        end else if (in_valid && in_ready) begin
            valid <= 1'b1;
            val   <= in_sum + in_carry;
            last  <= in_last;
        end else if (advance) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/ne_dot_accum.sv
// ne_dot_accum: streaming signed dot-product accumulator fed by a carry-save tree
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_sum/in_carry/in_last input beats;
//        out_valid/out_ready/out_acc/out_cnt/out_ovf result port (registered).
module ne_dot_accum
    import ne_dot_pkg::*;
#(
    parameter int IN_W  = ne_dot_pkg::IN_W,
    parameter int ACC_W = ne_dot_pkg::ACC_W,
    parameter int CNT_W = ne_dot_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    input  logic [IN_W-1:0]  in_carry,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf
);
    logic             s1_valid, s1_last, s1_adv, ov;
    logic [IN_W-1:0]  s1_val;
    logic [ACC_W-1:0] acc, ext, nxt;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             ovf;
    acc_state_t       state;

    // only a last beat can be blocked: it would overwrite a result not yet taken
    assign s1_adv  = s1_valid && !(s1_last && out_valid && !out_ready);
    assign ext     = {{(ACC_W-IN_W){s1_val[IN_W-1]}}, s1_val};
    assign nxt     = acc + ext;
    assign ov      = (acc[ACC_W-1] == ext[ACC_W-1]) && (nxt[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);

    ne_cpa #(.W(IN_W)) u_cpa (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sum   (in_sum),
        .in_carry (in_carry),
        .in_last  (in_last),
        .advance  (s1_adv),
        .valid    (s1_valid),
        .val      (s1_val),
        .last     (s1_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_cnt   <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (s1_adv && !s1_last) begin
                acc <= nxt;
                cnt <= cnt_inc;
                ovf <= ovf | ov;
            end
            if (s1_adv && s1_last) begin
                out_acc   <= nxt;
                out_cnt   <= cnt_inc;
                out_ovf   <= ovf | ov;
                out_valid <= 1'b1;
                state     <= HOLD;
                acc       <= '0;
                cnt       <= '0;
                ovf       <= 1'b0;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                state     <= IDLE_ACC;
            end
        end
    end
endmodule

// File: tb/tb_ne_dot_accum.sv
// tb_ne_dot_accum: directed self-checking bench for ne_dot_accum
module tb_ne_dot_accum;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, in_last = 0, out_ready = 1;
    logic [30:0] in_sum = '0, in_carry = '0;
    logic        r0, r1, r2, v0, v1, v2, f0, f1, f2;
    logic [39:0] a0, a2;
    logic [31:0] a1;
    logic [7:0]  c0, c1;
    logic [1:0]  c2;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    ne_dot_accum u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_sum(in_sum),
        .in_carry(in_carry), .in_last(in_last), .out_valid(v0), .out_ready(out_ready),
        .out_acc(a0), .out_cnt(c0), .out_ovf(f0));
    ne_dot_accum #(.ACC_W(32)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last), .out_valid(v1),
        .out_ready(out_ready), .out_acc(a1), .out_cnt(c1), .out_ovf(f1));
    ne_dot_accum #(.CNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r2),
        .in_sum(in_sum), .in_carry(in_carry), .in_last(in_last), .out_valid(v2),
        .out_ready(out_ready), .out_acc(a2), .out_cnt(c2), .out_ovf(f2));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [30:0] s, input logic [30:0] c, input logic l);
        int k;
        in_sum = s;
        in_carry = c;
        in_last = l;
        in_valid = 1;
        for (k = 0; k < 50; k++) begin
            @(negedge clk);
            if (r0) break;
        end
        if (k == 50) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
        in_last = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_valid", v0, 0);
        chk("rst_ready", r0, 1);
        chk("rst_acc", a0, 0);
        tick();
        rst_n = 1;
        tick();
        send(31'd5, 31'd3, 1);
        tick();
        chk("single_valid", v0, 1);
        chk("single_acc", a0, 40'd8);
        chk("single_cnt", c0, 1);
        chk("single_ovf", f0, 0);
        tick();
        chk("single_idle", v0, 0);
        send(31'h7FFFFFFF, 31'h1, 0);
        send(31'h10, 31'h0, 1);
        tick();
        chk("wrap_acc", a0, 40'd16);
        chk("wrap_cnt", c0, 2);
        tick();
        out_ready = 0;
        send(31'd1, 31'd0, 1);
        send(31'd2, 31'd0, 1);
        chk("bp_valid", v0, 1);
        chk("bp_acc1", a0, 40'd1);
        chk("bp_stall", r0, 0);
        tick();
        chk("bp_hold_acc", a0, 40'd1);
        chk("bp_hold_stall", r0, 0);
        out_ready = 1;
        #1;
        chk("bp_release_ready", r0, 1);
        tick();
        chk("bp_b2b_valid", v0, 1);
        chk("bp_acc2", a0, 40'd2);
        tick();
        chk("bp_drain", v0, 0);
        send(31'h3FFFFFFF, 31'h0, 0);
        send(31'h3FFFFFFF, 31'h0, 0);
        send(31'h3FFFFFFF, 31'h0, 1);
        tick();
        chk("ovf32_flag", f1, 1);
        chk("ovf32_acc", a1, 32'hBFFFFFFD);
        chk("ovf32_cnt", c1, 3);
        chk("ovf40_flag", f0, 0);
        chk("ovf40_acc", a0, 40'h00BFFFFFFD);
        send(31'd1, 31'd0, 1);
        tick();
        chk("ovf_clear_flag", f1, 0);
        chk("ovf_clear_acc", a1, 32'd1);
        for (int i = 0; i < 5; i++) send(31'd1, 31'd0, i == 4);
        tick();
        chk("sat_cnt", c2, 3);
        chk("sat_acc", a2, 40'd5);
        chk("nosat_cnt", c0, 5);
        for (int i = 0; i < 3; i++) send(31'd7, 31'd0, 0);
        rst_n = 0;
        #1;
        chk("mid_rst_valid", v0, 0);
        chk("mid_rst_acc", a0, 0);
        chk("mid_rst_cnt", c0, 0);
        chk("mid_rst_ovf", f0, 0);
        chk("mid_rst_ready", {r0, r1, r2}, 3'b111);
        tick();
        rst_n = 1;
        tick();
        send(31'd4, 31'd0, 1);
        tick();
        chk("post_rst_acc", a0, 40'd4);
        chk("post_rst_cnt", c0, 1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
